audio_src_sched: RTL and testbench
==================================

Name: audio_src_sched

Overview:
- Per-sample scheduler and mixer in front of AUDIO_OUT.
- Generates the output sample-rate tick from CLK50M with a fractional divider.
- On each tick, polls NSRC sound sources in fixed order over a valid/ack handshake and sums the accepted samples per channel.
- Saturates the sums to 16 bits and holds them stable on oL/oR (signed two's complement), which feed AUDIO_OUT iL/iR.

Parameters:
- NSRC, 4, number of sound sources (1..8).
- CLK_HZ, 50000000, CLK50M frequency in Hz.
- FS_HZ, 48000, output sample rate in Hz. CLK_HZ/FS_HZ must be greater than NSRC+3.

Ports:
- CLK50M  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- iREQ  in  NSRC  source i has a sample ready; held until acknowledged.
- iSMP_L  in  16*NSRC  left sample, signed; source i occupies bits [16i+15:16i].
- iSMP_R  in  16*NSRC  right sample, same packing as iSMP_L.
- iMUTE  in  NSRC  source i is drained but contributes zero.
- iCLR  in  1  clears the sticky status flags.
- oACK  out  NSRC  one-cycle acknowledge per source; at most one bit high in any cycle.
- oL  out  16  mixed left sample.
- oR  out  16  mixed right sample.
- oSTB  out  1  one-cycle pulse when oL/oR update.
- oUNDER  out  NSRC  sticky underrun flag per source.

Behaviour:
- Clock and reset: one clock, CLK50M. Reset is asynchronous, active-low RESET_N; all state clears on assertion. While reset is active: oL=0, oR=0, oSTB=0, oACK=0, oUNDER=0, phase accumulator=0, FSM=IDLE.
- Rate generator: 32-bit phase accumulator.
  - Each cycle: if acc+FS_HZ >= CLK_HZ, then acc <= acc+FS_HZ-CLK_HZ and a registered one-cycle tick fires; otherwise acc <= acc+FS_HZ.
  - Long-run tick rate is exactly FS_HZ. Tick spacing is floor or ceil of CLK_HZ/FS_HZ (1041 or 1042 at the defaults).
- FSM states:
  - IDLE: wait for tick. On tick, clear sumL/sumR and set idx=0; go to SCAN.
  - SCAN: one cycle per source, idx = 0..NSRC-1, ascending.
    - iREQ[idx]=1, iMUTE[idx]=0: oACK[idx]=1 this cycle; sign-extended samples are added to sumL/sumR.
    - iREQ[idx]=1, iMUTE[idx]=1: oACK[idx]=1; adds zero.
    - iREQ[idx]=0, iMUTE[idx]=0: no ack; adds zero; oUNDER[idx] is set.
    - iREQ[idx]=0, iMUTE[idx]=1: no ack, no flag.
    - After idx=NSRC-1, go to SAT.
  - SAT: clamp each sum to [-32768, +32767] and register the results into oL/oR. oSTB=1 on the following cycle. Go to IDLE.
- Sum width: 16+clog2(NSRC) bits, signed; no intermediate overflow is possible.
- Latency: from the tick cycle T, oACK for source i is high at T+1+i. New oL/oR and oSTB=1 appear at T+NSRC+2. oL/oR hold their value until the next update.
- Handshake rules:
  - A source must keep its sample stable while iREQ=1 and may change it only after the cycle in which oACK is high.
  - iREQ dropping in the same cycle as its scan slot counts as not ready.
  - At most one sample is taken per source per tick.
- Sticky flags: if iCLR and a set event occur in the same cycle, set wins. iCLR clears all other oUNDER bits.
- Tick outside IDLE: latched in a pending flag and serviced on the first IDLE cycle. This cannot occur with legal parameters; the pending flag is kept for robustness.
- Reset mid-scan: the partial sums are discarded; oL/oR read 0 until the first full frame completes after release.

Optional Feature:
- Macro: AUDIO_SCHED_CLIP_EN.
- Defined: adds port oCLIP (out, 1 bit), sticky. It is set in the SAT cycle if either channel clamps and is cleared by iCLR; set wins over iCLR.
- Undefined: the port is absent and there is no clip logic. Saturation is applied in both cases.

Decomposition:
- Package audio_sched_pkg holds:
  - SMP_W=16;
  - the state encoding {IDLE, SCAN, SAT};
  - the function sum_w(n) = 16+clog2(n);
  - the saturation function sat16().
- Sub-module audio_rate_gen: the fractional divider. Inputs CLK50M and RESET_N, parameters CLK_HZ/FS_HZ, output tick.

Test Plan:
- Rate: defaults, count ticks over 50,000,000 cycles -> exactly 48000 oSTB pulses; every spacing is 1041 or 1042.
- Basic mix: src0 L=+1000/R=-1000, src1 L=+234/R=+34, others muted with iREQ=1 -> oL=+1234, oR=-966. oACK bits are at T+1..T+4 and oSTB is at T+6.
- Saturation: all 4 sources L=+32000 and R=-32000 -> oL=+32767, oR=-32768. oCLIP=1 with AUDIO_SCHED_CLIP_EN defined; the port is absent when the macro is undefined.
- Underrun: src2 holds iREQ=0 and is unmuted -> oUNDER=4'b0100, and src2 is excluded from the sum. Pulse iCLR in the same cycle as src2's next empty slot -> the flag stays 1. Pulse iCLR on a later cycle -> the flag clears.
- Handshake: src1 drops iREQ in its scan cycle -> no oACK[1], oUNDER[1]=1. A source never sees two acks within one tick period.
- Reset: assert RESET_N=0 during SCAN at idx=2 -> all outputs read 0 immediately. After release, the first oSTB arrives only after a full tick-to-strobe frame.

Source files
------------

// File: rtl/audio_src_sched_pkg.sv
// Shared types and arithmetic helpers for the audio source scheduler.
// Optional clip reporting is enabled by defining AUDIO_SCHED_CLIP_EN.
package audio_sched_pkg;

    localparam int SMP_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SAT  = 2'd2
    } sched_state_e;

    function automatic int sum_w(input int n);
        return SMP_W + $clog2(n);
    endfunction

    function automatic logic signed [SMP_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[SMP_W-1:0];
        end
    endfunction

    function automatic logic sat_hit(input logic signed [31:0] v);
        return (v > 32'sd32767) || (v < -32'sd32768);
    endfunction

endpackage

// File: rtl/audio_src_sched_if.sv
// Source-side bus of the audio scheduler: per-source request/ack, samples, mixed output.
// oCLIP exists only when AUDIO_SCHED_CLIP_EN is defined.
interface audio_src_sched_if #(parameter int NSRC = 4);

    logic [NSRC-1:0]    iREQ;
    logic [16*NSRC-1:0] iSMP_L;
    logic [16*NSRC-1:0] iSMP_R;
    logic [NSRC-1:0]    iMUTE;
    logic               iCLR;
    logic [NSRC-1:0]    oACK;
    logic [15:0]        oL;
    logic [15:0]        oR;
    logic               oSTB;
    logic [NSRC-1:0]    oUNDER;
`ifdef AUDIO_SCHED_CLIP_EN
    logic               oCLIP;

    modport master (output iREQ, iSMP_L, iSMP_R, iMUTE, iCLR,
                    input  oACK, oL, oR, oSTB, oUNDER, oCLIP);
    modport slave  (input  iREQ, iSMP_L, iSMP_R, iMUTE, iCLR,
                    output oACK, oL, oR, oSTB, oUNDER, oCLIP);
`else
    modport master (output iREQ, iSMP_L, iSMP_R, iMUTE, iCLR,
                    input  oACK, oL, oR, oSTB, oUNDER);
    modport slave  (input  iREQ, iSMP_L, iSMP_R, iMUTE, iCLR,
                    output oACK, oL, oR, oSTB, oUNDER);
`endif

endinterface

// File: rtl/audio_src_sched_rate_gen.sv
// Fractional divider: emits a registered one-cycle tick at an average rate of exactly FS_HZ.
module audio_rate_gen #(
    parameter int CLK_HZ = 50000000,
    parameter int FS_HZ  = 48000
) (
    input  logic CLK50M,
    input  logic RESET_N,
    output logic tick
);

    logic [31:0] acc_r;
    logic [32:0] nxt_s;

    assign nxt_s = {1'b0, acc_r} + 33'(FS_HZ);

    // Phase accumulator; wraps by CLK_HZ and flags the wrap as the tick.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_r <= 32'd0;
            tick  <= 1'b0;
        end else if (nxt_s >= 33'(CLK_HZ)) begin
            acc_r <= 32'(nxt_s - 33'(CLK_HZ));
            tick  <= 1'b1;
        end else begin
            acc_r <= nxt_s[31:0];
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_src_sched.sv
// Per-sample scheduler/mixer: polls NSRC sources each output tick, sums and saturates to 16 bits.
// Define AUDIO_SCHED_CLIP_EN to add the sticky oCLIP flag.
module audio_src_sched
    import audio_sched_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int CLK_HZ = 50000000,
    parameter int FS_HZ  = 48000
) (
    input  logic             CLK50M,
    input  logic             RESET_N,
    audio_src_sched_if.slave bus
);

    localparam int SW = sum_w(NSRC);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic                    tick_s;
    sched_state_e            state_r;
    logic [IW-1:0]           idx_r;
    logic signed [SW-1:0]    sum_l_r;
    logic signed [SW-1:0]    sum_r_r;
    logic                    pend_r;
    logic [SMP_W-1:0]        out_l_r;
    logic [SMP_W-1:0]        out_r_r;
    logic                    stb_r;
    logic [NSRC-1:0]         under_r;

    logic                    slot_req_s;
    logic                    slot_mute_s;
    logic signed [SMP_W-1:0] slot_l_s;
    logic signed [SMP_W-1:0] slot_r_s;
    logic [NSRC-1:0]         ack_s;
    logic [NSRC-1:0]         under_set_s;
    logic                    take_s;

    audio_rate_gen #(.CLK_HZ(CLK_HZ), .FS_HZ(FS_HZ)) u_rate (
        .CLK50M  (CLK50M),
        .RESET_N (RESET_N),
        .tick    (tick_s)
    );

    // Current scan slot: ack follows the live request so a request dropped in its slot is missed.
    always_comb begin
        slot_req_s  = bus.iREQ[idx_r];
        slot_mute_s = bus.iMUTE[idx_r];
        slot_l_s    = bus.iSMP_L[SMP_W*int'(idx_r) +: SMP_W];
        slot_r_s    = bus.iSMP_R[SMP_W*int'(idx_r) +: SMP_W];
        ack_s       = '0;
        under_set_s = '0;
        take_s      = 1'b0;
        if (state_r == SCAN) begin
            if (slot_req_s) begin
                ack_s[idx_r] = 1'b1;
                take_s       = ~slot_mute_s;
            end else if (!slot_mute_s) begin
                under_set_s[idx_r] = 1'b1;
            end else begin
                under_set_s = '0;
            end
        end else begin
            take_s = 1'b0;
        end
    end

    // Scheduler FSM with accumulators, held outputs and sticky underrun flags.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
            idx_r   <= '0;
            sum_l_r <= '0;
            sum_r_r <= '0;
            pend_r  <= 1'b0;
            out_l_r <= '0;
            out_r_r <= '0;
            stb_r   <= 1'b0;
            under_r <= '0;
        end else begin
            stb_r   <= 1'b0;
            under_r <= (bus.iCLR ? {NSRC{1'b0}} : under_r) | under_set_s;
            case (state_r)
                IDLE: begin
                    if (tick_s || pend_r) begin
                        state_r <= SCAN;
                        idx_r   <= '0;
                        sum_l_r <= '0;
                        sum_r_r <= '0;
                        pend_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (tick_s) begin
                        pend_r <= 1'b1;
                    end else begin
                        pend_r <= pend_r;
                    end
                    if (take_s) begin
                        sum_l_r <= sum_l_r + SW'(slot_l_s);
                        sum_r_r <= sum_r_r + SW'(slot_r_s);
                    end else begin
                        sum_l_r <= sum_l_r;
                    end
                    if (idx_r == IW'(NSRC - 1)) begin
                        state_r <= SAT;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                SAT: begin
                    if (tick_s) begin
                        pend_r <= 1'b1;
                    end else begin
                        pend_r <= pend_r;
                    end
                    out_l_r <= sat16(32'(sum_l_r));
                    out_r_r <= sat16(32'(sum_r_r));
                    stb_r   <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef AUDIO_SCHED_CLIP_EN
    logic clip_r;

    // Sticky clip flag: a clamp in the SAT cycle wins over a simultaneous clear.
    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            clip_r <= 1'b0;
        end else begin
            clip_r <= (bus.iCLR ? 1'b0 : clip_r) |
                      ((state_r == SAT) && (sat_hit(32'(sum_l_r)) || sat_hit(32'(sum_r_r))));
        end
    end

    assign bus.oCLIP = clip_r;
`endif

    assign bus.oACK   = ack_s;
    assign bus.oL     = out_l_r;
    assign bus.oR     = out_r_r;
    assign bus.oSTB   = stb_r;
    assign bus.oUNDER = under_r;

endmodule

// File: tb/tb_audio_src_sched.sv
// Self-checking bench for audio_src_sched: random and directed traffic against a frame-level model.
// Compile with AUDIO_SCHED_CLIP_EN defined to also check oCLIP.
module tb_audio_src_sched;

    localparam int NSRC   = 4;
    localparam int CLK_HZ = 1000;
    localparam int FS_HZ  = 48;
    localparam int GAP_LO = CLK_HZ / FS_HZ;
    localparam int GAP_HI = (CLK_HZ + FS_HZ - 1) / FS_HZ;

    typedef enum int {M_RAND, M_MIX, M_SAT, M_UNDER, M_DROP} mode_e;

    logic CLK50M = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK50M = ~CLK50M;

    audio_src_sched_if #(.NSRC(NSRC)) bus ();

    audio_src_sched #(.NSRC(NSRC), .CLK_HZ(CLK_HZ), .FS_HZ(FS_HZ)) dut (
        .CLK50M  (CLK50M),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    mode_e             mode = M_RAND;
    int                clr_slot = -99;
    logic [NSRC-1:0]   req_v = '0;
    logic [NSRC-1:0]   mute_v = '0;
    logic              clr_v = 1'b0;
    logic signed [15:0] smp_l [NSRC];
    logic signed [15:0] smp_r [NSRC];

    longint          cyc = 0;
    int              cur_slot = -99;
    int              sum_l = 0;
    int              sum_r = 0;
    logic [NSRC-1:0] m_under = '0;
    logic            m_clip = 1'b0;
    logic [15:0]     m_l = '0;
    logic [15:0]     m_r = '0;
    int              ack_cnt [NSRC];
    longint          stb_cnt = 0;
    longint          last_stb = -1;
    longint          first_stb = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        else if (v < -32768) return -32768;
        else return v;
    endfunction

    // Cycle of the most recent tick at or before cycle c (cycle 1 = first edge after reset).
    function automatic longint last_tick(input longint c);
        longint n;
        n = (longint'(FS_HZ) * c) / CLK_HZ;
        if (n == 0) return -1000;
        return (n * CLK_HZ + FS_HZ - 1) / FS_HZ;
    endfunction

    task automatic gen(input int slot);
        clr_v = (slot == clr_slot);
        for (int i = 0; i < NSRC; i++) begin
            case (mode)
                M_RAND: begin
                    req_v[i]  = ($urandom_range(0, 3) != 0);
                    mute_v[i] = ($urandom_range(0, 3) == 0);
                    smp_l[i]  = 16'($urandom);
                    smp_r[i]  = 16'($urandom);
                end
                M_MIX: begin
                    req_v[i]  = 1'b1;
                    mute_v[i] = (i >= 2);
                    smp_l[i]  = (i == 0) ? 16'sd1000  : (i == 1) ? 16'sd234 : 16'($urandom);
                    smp_r[i]  = (i == 0) ? -16'sd1000 : (i == 1) ? 16'sd34  : 16'($urandom);
                end
                M_SAT: begin
                    req_v[i]  = 1'b1;
                    mute_v[i] = 1'b0;
                    smp_l[i]  = 16'sd32000;
                    smp_r[i]  = -16'sd32000;
                end
                M_UNDER: begin
                    req_v[i]  = (i != 2);
                    mute_v[i] = 1'b0;
                    smp_l[i]  = (i == 2) ? 16'sd4000  : 16'(100 * (i == 3 ? 3 : i + 1));
                    smp_r[i]  = (i == 2) ? -16'sd4000 : -16'sd50;
                end
                default: begin
                    req_v[i]  = !(i == 1 && slot == 1);
                    mute_v[i] = 1'b0;
                    smp_l[i]  = 16'sd10;
                    smp_r[i]  = -16'sd10;
                end
            endcase
        end
        if (mode == M_RAND) clr_v = ($urandom_range(0, 15) == 0);
        bus.iREQ  = req_v;
        bus.iMUTE = mute_v;
        bus.iCLR  = clr_v;
        for (int i = 0; i < NSRC; i++) begin
            bus.iSMP_L[16*i +: 16] = smp_l[i];
            bus.iSMP_R[16*i +: 16] = smp_r[i];
        end
    endtask

    task automatic step();
        longint t;
        int slot;
        logic [NSRC-1:0] e_ack, u_set;
        logic c_set, e_stb;
        @(posedge CLK50M);
        cyc++;
        #2;
        t = last_tick(cyc);
        slot = int'(cyc - t) - 1;
        cur_slot = slot;
        gen(slot);
        #1;
        e_ack = '0; u_set = '0; c_set = 1'b0; e_stb = 1'b0;
        if (cyc == t) begin
            sum_l = 0; sum_r = 0;
            for (int i = 0; i < NSRC; i++) ack_cnt[i] = 0;
        end
        if (t > 0 && slot >= 0 && slot < NSRC) begin
            if (req_v[slot]) begin
                e_ack[slot] = 1'b1;
                if (!mute_v[slot]) begin
                    sum_l += int'(smp_l[slot]);
                    sum_r += int'(smp_r[slot]);
                end
            end else if (!mute_v[slot]) begin
                u_set[slot] = 1'b1;
            end
        end
        if (t > 0 && slot == NSRC)
            c_set = (clamp16(sum_l) != sum_l) || (clamp16(sum_r) != sum_r);
        if (t > 0 && slot == NSRC + 1) begin
            e_stb = 1'b1;
            m_l = 16'(clamp16(sum_l));
            m_r = 16'(clamp16(sum_r));
        end
        for (int i = 0; i < NSRC; i++) if (bus.oACK[i] === 1'b1) ack_cnt[i]++;
        chk("oACK", 32'(bus.oACK), 32'(e_ack));
        chk("oSTB", 32'(bus.oSTB), 32'(e_stb));
        chk("oL", 32'(bus.oL), 32'(m_l));
        chk("oR", 32'(bus.oR), 32'(m_r));
        chk("oUNDER", 32'(bus.oUNDER), 32'(m_under));
`ifdef AUDIO_SCHED_CLIP_EN
        chk("oCLIP", 32'(bus.oCLIP), 32'(m_clip));
`endif
        if (bus.oSTB === 1'b1) begin
            stb_cnt++;
            if (first_stb < 0) first_stb = cyc;
            if (last_stb >= 0)
                chk("stb_gap", 32'((cyc - last_stb == GAP_LO) || (cyc - last_stb == GAP_HI)), 32'd1);
            last_stb = cyc;
            for (int i = 0; i < NSRC; i++) chk("one_ack_per_tick", 32'(ack_cnt[i] <= 1), 32'd1);
        end
        m_under = (clr_v ? {NSRC{1'b0}} : m_under) | u_set;
        m_clip  = (clr_v ? 1'b0 : m_clip) | c_set;
    endtask

    // Steps to the next tick under the new mode, then through n complete frames.
    task automatic run_frames(input mode_e m, input int n, input int cs);
        int k;
        int seen;
        mode = m;
        clr_slot = cs;
        k = 0;
        do begin
            step();
            k++;
        end while (cur_slot != -1 && k < 3 * GAP_HI);
        if (cur_slot != -1) fail_timeout("wait_tick");
        seen = 0;
        k = 0;
        while (seen < n && k < n * 3 * GAP_HI) begin
            step();
            k++;
            if (cur_slot == NSRC + 1) seen++;
        end
        if (seen < n) fail_timeout("wait_frame");
    endtask

    task automatic model_reset();
        cyc = 0; sum_l = 0; sum_r = 0; m_under = '0; m_clip = 1'b0;
        m_l = '0; m_r = '0; stb_cnt = 0; last_stb = -1; first_stb = -1;
        for (int i = 0; i < NSRC; i++) ack_cnt[i] = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_oL"}, 32'(bus.oL), 32'd0);
        chk({tag, "_oR"}, 32'(bus.oR), 32'd0);
        chk({tag, "_oSTB"}, 32'(bus.oSTB), 32'd0);
        chk({tag, "_oACK"}, 32'(bus.oACK), 32'd0);
        chk({tag, "_oUNDER"}, 32'(bus.oUNDER), 32'd0);
`ifdef AUDIO_SCHED_CLIP_EN
        chk({tag, "_oCLIP"}, 32'(bus.oCLIP), 32'd0);
`endif
    endtask

    initial begin
        int k;
        model_reset();
        mode = M_RAND;
        gen(-99);
        repeat (3) @(posedge CLK50M);
        #3;
        chk_all_zero("reset");
        @(posedge CLK50M);
        #2;
        RESET_N = 1'b1;

        // Random traffic, then long-run rate check.
        repeat (2000) step();
        chk("tick_count", 32'(stb_cnt), 32'((longint'(FS_HZ) * (cyc - NSRC - 2)) / CLK_HZ));

        run_frames(M_MIX, 1, 0);
        chk("mix_oL", 32'(bus.oL), 32'h0000_04D2);
        chk("mix_oR", 32'(bus.oR), 32'h0000_FC3A);
`ifdef AUDIO_SCHED_CLIP_EN
        chk("mix_oCLIP", 32'(bus.oCLIP), 32'd0);
`endif

        run_frames(M_SAT, 1, -99);
        chk("sat_oL", 32'(bus.oL), 32'h0000_7FFF);
        chk("sat_oR", 32'(bus.oR), 32'h0000_8000);
`ifdef AUDIO_SCHED_CLIP_EN
        chk("sat_oCLIP", 32'(bus.oCLIP), 32'd1);
`endif

        run_frames(M_UNDER, 1, 0);
        chk("under_flag", 32'(bus.oUNDER), 32'h4);
        chk("under_oL", 32'(bus.oL), 32'h0000_0258);
        chk("under_oR", 32'(bus.oR), 32'h0000_FF6A);
        run_frames(M_UNDER, 1, 2);
        chk("under_set_wins", 32'(bus.oUNDER), 32'h4);
        run_frames(M_UNDER, 1, 3);
        chk("under_cleared", 32'(bus.oUNDER), 32'h0);

        run_frames(M_DROP, 1, 0);
        chk("drop_under", 32'(bus.oUNDER), 32'h2);
        chk("drop_oL", 32'(bus.oL), 32'h0000_001E);

        run_frames(M_RAND, 20, -99);
        chk("tick_count2", 32'(stb_cnt), 32'((longint'(FS_HZ) * (cyc - NSRC - 2)) / CLK_HZ));

        // Reset in the middle of a scan, at source 2's slot.
        run_frames(M_UNDER, 1, -99);
        k = 0;
        do begin
            step();
            k++;
        end while (cur_slot != 2 && k < 3 * GAP_HI);
        if (cur_slot != 2) fail_timeout("wait_slot2");
        chk("pre_reset_oL", 32'(bus.oL), 32'h0000_0258);
        RESET_N = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge CLK50M);
        #2;
        RESET_N = 1'b1;
        model_reset();
        mode = M_MIX;
        clr_slot = -99;
        repeat (GAP_HI + NSRC + 6) step();
        chk("first_stb_after_reset", 32'(first_stb), 32'(GAP_HI + NSRC + 2));
        chk("post_reset_oL", 32'(bus.oL), 32'h0000_04D2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
